// File: rtl/simon_encrypt_rounds.sv
// Iterative SIMON encryption datapath: accepts one block while the round keys
// are valid, applies one Feistel round per clock, then pulses doneData.
module simon_encrypt_rounds #(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int Cb = 5
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic                  newData,
  input  logic                  doneKey,
  input  logic [T-1:0][N-1:0]   keys,
  input  logic [1:0][N-1:0]     plaintext,
  output logic [1:0][N-1:0]     ciphertext,
  output logic                  doneData,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [Cb-1:0] LAST_ROUND = Cb'(T - 1);

  generate
    if ((2 ** Cb) < T || M < 2) begin : g_param_check
      $error("simon_encrypt_rounds: Cb too small for T, or M out of range");
    end
  endgenerate

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] round_f(input logic [N-1:0] v);
    return (rotl(v, 32'd1) & rotl(v, 32'd8)) ^ rotl(v, 32'd2);
  endfunction

  state_e             state_q;
  logic [N-1:0]       x_q;
  logic [N-1:0]       y_q;
  logic [Cb-1:0]      count_q;
  logic [1:0][N-1:0]  ciphertext_q;
  logic               done_data_q;
  logic [N-1:0]       x_d;
  logic [Cb-1:0]      count_d;

  // Next x word and round counter for the round currently in progress.
  always_comb begin
    x_d = y_q ^ round_f(x_q) ^ keys[count_q];
    if (count_q == LAST_ROUND) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{(Cb-1){1'b0}}, 1'b1};
    end
  end

  // Control FSM together with the datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      count_q      <= '0;
      ciphertext_q <= '0;
      done_data_q  <= 1'b0;
    end else begin
      done_data_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (newData && doneKey) begin
            x_q     <= plaintext[1];
            y_q     <= plaintext[0];
            count_q <= '0;
            state_q <= S_ROUND;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ROUND: begin
          // Losing the keys mid-block abandons it without touching ciphertext.
          if (!doneKey) begin
            state_q <= S_IDLE;
          end else begin
            x_q     <= x_d;
            y_q     <= x_q;
            count_q <= count_d;
            if (count_q == LAST_ROUND) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_ROUND;
            end
          end
        end
        S_DONE: begin
          ciphertext_q <= {x_q, y_q};
          done_data_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ciphertext = ciphertext_q;
  assign doneData   = done_data_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_simon_encrypt_rounds.sv
// Scoreboard bench for simon_encrypt_rounds: a reference SIMON32/64 model
// predicts each ciphertext and its arrival cycle; a monitor checks every pulse.
module tb_simon_encrypt_rounds;

  typedef logic [31:0][15:0] ks_t;
  typedef struct {
    logic [31:0] ct;
    int          due;
  } exp_t;

  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;

  logic        clk = 1'b0;
  logic        R;
  logic        newData;
  logic        doneKey;
  ks_t         keys;
  logic [31:0] plaintext;
  logic [31:0] ciphertext;
  logic        doneData;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ncyc     = 0;
  exp_t        exp_q[$];
  logic [31:0] last_exp = 32'h0;

  simon_encrypt_rounds dut (
    .clk        (clk),
    .R          (R),
    .newData    (newData),
    .doneKey    (doneKey),
    .keys       (keys),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .doneData   (doneData),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rol(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] ror(input logic [15:0] v, input int s);
    return rol(v, 16 - s);
  endfunction

  // SIMON32/64 key schedule, z0 sequence read from its first character onward.
  function automatic ks_t expand(input logic [63:0] key);
    ks_t         k;
    logic [15:0] tmp;
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    k[0] = key[15:0];
    k[1] = key[31:16];
    k[2] = key[47:32];
    k[3] = key[63:48];
    for (int i = 4; i < 32; i++) begin
      tmp  = ror(k[i-1], 3) ^ k[i-3];
      tmp  = tmp ^ ror(tmp, 1);
      k[i] = ~k[i-4] ^ tmp ^ {15'd0, z[61 - ((i - 4) % 62)]} ^ 16'd3;
    end
    return k;
  endfunction

  function automatic logic [31:0] encrypt(input logic [31:0] pt, input ks_t k);
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] t;
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ct, input int due);
    exp_t e;
    e.ct  = ct;
    e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic quiet(input int n);
    repeat (n) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ciphertext"}, 64'(ciphertext), 64'd0);
    check({tag, "_doneData"}, 64'(doneData), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Monitor: every doneData pulse must match the oldest expected result and arrive on time.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (doneData) begin
      if (exp_q.size() == 0) begin
        check("unexpected_doneData", 64'(ciphertext), 64'hffff_ffff_ffff_ffff);
      end else begin
        e = exp_q.pop_front();
        last_exp = e.ct;
        check("ciphertext", 64'(ciphertext), 64'(e.ct));
        check("latency", 64'(ncyc), 64'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          busy_cnt;
    int          n0;
    ks_t         kat_keys;
    logic [63:0] rkey;
    logic [31:0] rpt;

    kat_keys  = expand(KAT_KEY);
    R         = 1'b1;
    newData   = 1'b0;
    doneKey   = 1'b0;
    keys      = kat_keys;
    plaintext = 32'h0;
    tick();
    tick();
    check_reset_outputs("reset");
    R       = 1'b0;
    doneKey = 1'b1;

    // Known answer with busy-window length.
    plaintext = KAT_PT;
    newData   = 1'b1;
    push(KAT_CT, ncyc + 34);
    tick();
    newData  = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      busy_cnt++;
      tick();
    end
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    wait_drain();

    // Gating on doneKey.
    doneKey  = 1'b0;
    newData  = 1'b1;
    busy_cnt = 0;
    repeat (10) begin
      tick();
      if (busy) busy_cnt++;
    end
    check("gated_busy", 64'(busy_cnt), 64'd0);
    doneKey = 1'b1;
    push(KAT_CT, ncyc + 34);
    tick();
    check("gated_accept_busy", 64'(busy), 64'd1);
    newData = 1'b0;
    wait_drain();
    quiet(5);

    // Request while busy is dropped.
    newData = 1'b1;
    push(KAT_CT, ncyc + 34);
    tick();
    newData = 1'b0;
    quiet(10);
    plaintext = 32'h1234_5678;
    newData   = 1'b1;
    tick();
    newData   = 1'b0;
    plaintext = KAT_PT;
    wait_drain();
    quiet(40);

    // Back-to-back with newData held.
    n0        = ncyc;
    newData   = 1'b1;
    push(KAT_CT, n0 + 34);
    push(encrypt(32'h0, kat_keys), n0 + 68);
    tick();
    plaintext = 32'h0;
    quiet(34);
    tick();
    newData   = 1'b0;
    wait_drain();
    quiet(5);

    // Abort at round 15.
    plaintext = KAT_PT;
    newData   = 1'b1;
    tick();
    newData = 1'b0;
    quiet(15);
    doneKey = 1'b0;
    tick();
    check("abort15_busy", 64'(busy), 64'd0);
    check("abort15_ciphertext", 64'(ciphertext), 64'(last_exp));
    doneKey = 1'b1;
    quiet(40);

    // Abort on the final round edge.
    newData = 1'b1;
    tick();
    newData = 1'b0;
    quiet(31);
    doneKey = 1'b0;
    tick();
    check("abort_last_busy", 64'(busy), 64'd0);
    check("abort_last_ciphertext", 64'(ciphertext), 64'(last_exp));
    doneKey = 1'b1;
    quiet(40);

    // Reset mid-operation, then a fresh request.
    newData = 1'b1;
    tick();
    newData = 1'b0;
    quiet(20);
    R = 1'b1;
    tick();
    R = 1'b0;
    check_reset_outputs("midreset");
    quiet(40);
    newData = 1'b1;
    push(KAT_CT, ncyc + 34);
    tick();
    newData = 1'b0;
    wait_drain();

    // Random keys and plaintexts against the reference model.
    for (int n = 0; n < 6; n++) begin
      rkey      = {$urandom, $urandom};
      rpt       = $urandom;
      keys      = expand(rkey);
      plaintext = rpt;
      newData   = 1'b1;
      push(encrypt(rpt, expand(rkey)), ncyc + 34);
      tick();
      newData = 1'b0;
      wait_drain();
      quiet(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
